// File: rtl/lc3_mmio_pkg.sv
// Shared definitions for the LC-3 memory responder: MMIO register addresses
// and the display port state type.
package lc3_mmio_pkg;

   localparam logic [15:0] KBSR_ADDR = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR = 16'hFE02;
   localparam logic [15:0] DSR_ADDR  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR  = 16'hFE06;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } disp_state_t;

endpackage

// File: rtl/lc3_disp_port.sv
// Display side of the DDR register: latches a character, offers it on a
// valid/ready stream, then keeps DSR busy for DISP_DELAY cycles after acceptance.
module lc3_disp_port
   import lc3_mmio_pkg::*;
#(
   parameter int DISP_DELAY = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ddr_we,
   input  logic [7:0] wdata,
   input  logic       disp_ready,
   output logic       disp_valid,
   output logic [7:0] disp_data,
   output logic       disp_rdy
);

   localparam logic [7:0] DELAY_M1 = 8'((DISP_DELAY > 0) ? DISP_DELAY - 1 : 0);

   disp_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        rdy_q, rdy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      rdy_d   = rdy_q;
      case (state_q)
         IDLE: begin
            if (ddr_we) begin
               data_d  = wdata;
               valid_d = 1'b1;
               rdy_d   = 1'b0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (disp_ready) begin
               valid_d = 1'b0;
               if (DISP_DELAY == 0) begin
                  rdy_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d   = DELAY_M1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // Counter starts at DISP_DELAY-1 so DSR is ready DISP_DELAY edges after the handshake.
            if (cnt_q == 8'd0) begin
               rdy_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            valid_d = 1'b0;
            rdy_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         rdy_q   <= rdy_d;
      end
   end

   assign disp_valid = valid_q;
   assign disp_data  = data_q;
   assign disp_rdy   = rdy_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder for the LC-3 core: word RAM plus KBSR/KBDR/DSR/DDR,
// with the keyboard and display registers bridged to valid/ready byte streams.
module lc3_mem_responder
   import lc3_mmio_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DISP_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] mar,
   input  logic [15:0] mdr,
   input  logic        memwe,
   output logic [15:0] memOut,
   input  logic [7:0]  kb_data,
   input  logic        kb_valid,
   output logic        kb_ready,
   output logic [7:0]  disp_data,
   output logic        disp_valid,
   input  logic        disp_ready
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [15:0] mem [DEPTH];

   logic        ram_hit, kbsr_hit, kbdr_hit, dsr_hit, ddr_hit;
   logic        kb_rd_evt;
   logic        disp_rdy;
   logic        kb_rdy_q, kb_rdy_d;
   logic        kb_ie_q, kb_ie_d;
   logic [7:0]  kb_char_q, kb_char_d;
   logic [15:0] mar_prev_q, mar_prev_d;

   assign ram_hit  = (mar[15:ADDR_W] == '0);
   assign kbsr_hit = (mar == KBSR_ADDR);
   assign kbdr_hit = (mar == KBDR_ADDR);
   assign dsr_hit  = (mar == DSR_ADDR);
   assign ddr_hit  = (mar == DDR_ADDR);

   // RAM is deliberately left without reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (memwe && ram_hit) begin
         mem[mar[ADDR_W-1:0]] <= mdr;
      end
   end

   // A KBDR read is the first cycle mar lands on KBDR, so a held mar consumes only once.
   assign kb_rd_evt = kbdr_hit && (mar_prev_q != mar);
   assign kb_ready  = !kb_rdy_q;

   always_comb begin
      kb_rdy_d   = kb_rdy_q;
      kb_char_d  = kb_char_q;
      kb_ie_d    = kb_ie_q;
      mar_prev_d = mar;
      if (kb_valid && kb_ready) begin
         kb_char_d = kb_data;
         kb_rdy_d  = 1'b1;
      end else if (kb_rd_evt) begin
         kb_rdy_d = 1'b0;
      end
      if (memwe && kbsr_hit) begin
         kb_ie_d = mdr[14];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kb_rdy_q   <= 1'b0;
         kb_ie_q    <= 1'b0;
         kb_char_q  <= 8'h00;
         mar_prev_q <= 16'h0000;
      end else begin
         kb_rdy_q   <= kb_rdy_d;
         kb_ie_q    <= kb_ie_d;
         kb_char_q  <= kb_char_d;
         mar_prev_q <= mar_prev_d;
      end
   end

   lc3_disp_port #(
      .DISP_DELAY (DISP_DELAY)
   ) u_disp_port (
      .clk        (clk),
      .reset_n    (reset_n),
      .ddr_we     (memwe && ddr_hit),
      .wdata      (mdr[7:0]),
      .disp_ready (disp_ready),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .disp_rdy   (disp_rdy)
   );

   always_comb begin
      memOut = 16'h0000;
      if (ram_hit) begin
         memOut = mem[mar[ADDR_W-1:0]];
      end else if (kbsr_hit) begin
         memOut = {kb_rdy_q, kb_ie_q, 14'b0};
      end else if (kbdr_hit) begin
         memOut = {8'h00, kb_char_q};
      end else if (dsr_hit) begin
         memOut = {disp_rdy, 15'b0};
      end else if (ddr_hit) begin
         memOut = {8'h00, disp_data};
      end
   end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Bench for lc3_mem_responder: directed scenarios plus randomized traffic
// checked against a transaction-level model of the memory map.
module tb_lc3_mem_responder;

   localparam int DISP_DELAY = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] mar = 16'h0000;
   logic [15:0] mdr = 16'h0000;
   logic        memwe = 1'b0;
   logic [15:0] memOut;
   logic [7:0]  kb_data = 8'h00;
   logic        kb_valid = 1'b0;
   logic        kb_ready;
   logic [7:0]  disp_data;
   logic        disp_valid;
   logic        disp_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [15:0] m_mem [256];
   bit          m_vld [256];
   bit          m_kb_full, m_kb_ie, m_disp_pend;
   logic [7:0]  m_kb_char, m_disp_char;
   logic [15:0] m_prev_mar;
   int          m_ready_edge;
   int          edges = 0;

   always #5 clk = ~clk;

   lc3_mem_responder #(
      .ADDR_W     (8),
      .DISP_DELAY (DISP_DELAY)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .mar        (mar),
      .mdr        (mdr),
      .memwe      (memwe),
      .memOut     (memOut),
      .kb_data    (kb_data),
      .kb_valid   (kb_valid),
      .kb_ready   (kb_ready),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .disp_ready (disp_ready)
   );

   function automatic void model_reset();
      m_kb_full    = 1'b0;
      m_kb_ie      = 1'b0;
      m_kb_char    = 8'h00;
      m_disp_pend  = 1'b0;
      m_disp_char  = 8'h00;
      m_prev_mar   = 16'h0000;
      m_ready_edge = edges;
   endfunction

   function automatic bit m_dsr();
      return !m_disp_pend && (edges >= m_ready_edge);
   endfunction

   function automatic logic [15:0] exp_read(input logic [15:0] a, output bit known);
      known = 1'b1;
      if (a[15:8] == 8'h00) begin
         known = m_vld[a[7:0]];
         return m_mem[a[7:0]];
      end
      case (a)
         16'hFE00: return {m_kb_full, m_kb_ie, 14'b0};
         16'hFE02: return {8'h00, m_kb_char};
         16'hFE04: return {m_dsr(), 15'b0};
         16'hFE06: return {8'h00, m_disp_char};
         default:  return 16'h0000;
      endcase
   endfunction

   // Apply the effect of the coming clock edge to the model, then advance the clock.
   task automatic tick();
      bit hs_kb, rd_evt, hs_disp;
      hs_kb   = kb_valid && !m_kb_full;
      rd_evt  = (mar == 16'hFE02) && (mar != m_prev_mar);
      hs_disp = m_disp_pend && disp_ready;
      if (memwe) begin
         if (mar[15:8] == 8'h00) begin
            m_mem[mar[7:0]] = mdr;
            m_vld[mar[7:0]] = 1'b1;
         end else if (mar == 16'hFE00) begin
            m_kb_ie = mdr[14];
         end else if (mar == 16'hFE06 && m_dsr()) begin
            m_disp_pend = 1'b1;
            m_disp_char = mdr[7:0];
         end
      end
      if (hs_kb) begin
         m_kb_full = 1'b1;
         m_kb_char = kb_data;
      end else if (rd_evt) begin
         m_kb_full = 1'b0;
      end
      if (hs_disp) begin
         m_disp_pend  = 1'b0;
         m_ready_edge = edges + 1 + DISP_DELAY;
      end
      m_prev_mar = mar;
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      model_reset();
      mar = 16'hFE00; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL reset_kbsr: got %h want 0000", memOut); end
      vectors++; if (kb_ready !== 1'b1) begin miscompares++; $display("FAIL reset_kb_ready: got %b want 1", kb_ready); end
      vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
      vectors++; if (disp_data !== 8'h00) begin miscompares++; $display("FAIL reset_disp_data: got %h want 00", disp_data); end
      mar = 16'hFE04; #1;
      vectors++; if (memOut !== 16'h8000) begin miscompares++; $display("FAIL reset_dsr: got %h want 8000", memOut); end
      mar = 16'hFE06; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL reset_ddr: got %h want 0000", memOut); end
      mar = 16'hFE02; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL reset_kbdr: got %h want 0000", memOut); end
      tick();
   endtask

   task automatic test_ram();
      mar = 16'h0000; mdr = 16'h5555; memwe = 1'b1; tick();
      mar = 16'h0010; mdr = 16'h1234; memwe = 1'b1; tick();
      memwe = 1'b0; #1;
      vectors++; if (memOut !== 16'h1234) begin miscompares++; $display("FAIL ram_rd_0010: got %h want 1234", memOut); end
      mar = 16'h0100; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL unmapped_rd: got %h want 0000", memOut); end
      mdr = 16'hBEEF; memwe = 1'b1; tick();
      memwe = 1'b0; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL unmapped_wr: got %h want 0000", memOut); end
      mar = 16'h0000; #1;
      vectors++; if (memOut !== 16'h5555) begin miscompares++; $display("FAIL unmapped_alias: got %h want 5555", memOut); end
      mar = 16'h0010; #1;
      vectors++; if (memOut !== 16'h1234) begin miscompares++; $display("FAIL ram_keep_0010: got %h want 1234", memOut); end
   endtask

   task automatic test_keyboard();
      mar = 16'hFE00; kb_valid = 1'b1; kb_data = 8'h41; tick();
      kb_valid = 1'b0; #1;
      vectors++; if (kb_ready !== 1'b0) begin miscompares++; $display("FAIL kb_ready_full: got %b want 0", kb_ready); end
      vectors++; if (memOut !== 16'h8000) begin miscompares++; $display("FAIL kbsr_full: got %h want 8000", memOut); end
      mar = 16'hFE02; #1;
      vectors++; if (memOut !== 16'h0041) begin miscompares++; $display("FAIL kbdr_char: got %h want 0041", memOut); end
      tick();
      mar = 16'hFE00; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL kbsr_cleared: got %h want 0000", memOut); end
      vectors++; if (kb_ready !== 1'b1) begin miscompares++; $display("FAIL kb_ready_cleared: got %b want 1", kb_ready); end
      mdr = 16'hFFFF; memwe = 1'b1; tick();
      memwe = 1'b0; #1;
      vectors++; if (memOut !== 16'h4000) begin miscompares++; $display("FAIL kbsr_ie_set: got %h want 4000", memOut); end
      mdr = 16'h0000; memwe = 1'b1; tick();
      memwe = 1'b0; #1;
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL kbsr_ie_clr: got %h want 0000", memOut); end
   endtask

   task automatic test_kb_hold();
      mar = 16'hFE02; tick();
      kb_valid = 1'b1; kb_data = 8'h42; tick();
      kb_valid = 1'b0; #1;
      vectors++; if (memOut !== 16'h0042) begin miscompares++; $display("FAIL hold_kbdr: got %h want 0042", memOut); end
      repeat (2) tick();
      vectors++; if (kb_ready !== 1'b0) begin miscompares++; $display("FAIL hold_kb_ready: got %b want 0", kb_ready); end
      mar = 16'hFE00; #1;
      vectors++; if (memOut !== 16'h8000) begin miscompares++; $display("FAIL hold_kbsr: got %h want 8000", memOut); end
      tick();
      mar = 16'hFE02; tick();
      vectors++; if (kb_ready !== 1'b1) begin miscompares++; $display("FAIL reread_kb_ready: got %b want 1", kb_ready); end
   endtask

   task automatic test_display();
      disp_ready = 1'b0;
      mar = 16'hFE06; mdr = 16'h0158; memwe = 1'b1; tick();
      memwe = 1'b0; mar = 16'hFE04;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++; if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid c%0d: got %b want 1", c, disp_valid); end
         vectors++; if (disp_data !== 8'h58) begin miscompares++; $display("FAIL bp_data c%0d: got %h want 58", c, disp_data); end
         vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL bp_dsr c%0d: got %h want 0000", c, memOut); end
         tick();
      end
      disp_ready = 1'b1; tick();
      disp_ready = 1'b0; #1;
      vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL hs_valid: got %b want 0", disp_valid); end
      vectors++; if (memOut !== 16'h0000) begin miscompares++; $display("FAIL hold_dsr k0: got %h want 0000", memOut); end
      for (int k = 1; k <= DISP_DELAY; k++) begin
         if (k == 1) begin
            mar = 16'hFE06; mdr = 16'h0077; memwe = 1'b1;
         end
         tick();
         memwe = 1'b0; mar = 16'hFE04; #1;
         vectors++;
         if (memOut !== ((k == DISP_DELAY) ? 16'h8000 : 16'h0000)) begin
            miscompares++;
            $display("FAIL hold_dsr k%0d: got %h want %h", k, memOut, (k == DISP_DELAY) ? 16'h8000 : 16'h0000);
         end
      end
      vectors++; if (disp_data !== 8'h58) begin miscompares++; $display("FAIL dropped_ddr: got %h want 58", disp_data); end
      vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL dropped_valid: got %b want 0", disp_valid); end
   endtask

   task automatic test_random();
      bit          known;
      logic [15:0] exp;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: mar = {8'h00, 8'($urandom_range(0, 255))};
            3:       mar = 16'hFE00;
            4:       mar = 16'hFE02;
            5:       mar = 16'hFE04;
            6:       mar = 16'hFE06;
            default: mar = 16'h0100 + 16'($urandom_range(0, 16'h0EFF));
         endcase
         mdr        = 16'($urandom);
         memwe      = ($urandom_range(0, 3) == 0);
         kb_valid   = ($urandom_range(0, 2) == 0);
         kb_data    = 8'($urandom);
         disp_ready = ($urandom_range(0, 1) == 1);
         #1;
         exp = exp_read(mar, known);
         if (known) begin
            vectors++;
            if (memOut !== exp) begin miscompares++; $display("FAIL rnd_read i%0d mar %h: got %h want %h", i, mar, memOut, exp); end
         end
         vectors++; if (kb_ready !== !m_kb_full) begin miscompares++; $display("FAIL rnd_kb_ready i%0d: got %b want %b", i, kb_ready, !m_kb_full); end
         vectors++; if (disp_valid !== m_disp_pend) begin miscompares++; $display("FAIL rnd_disp_valid i%0d: got %b want %b", i, disp_valid, m_disp_pend); end
         vectors++; if (disp_data !== m_disp_char) begin miscompares++; $display("FAIL rnd_disp_data i%0d: got %h want %h", i, disp_data, m_disp_char); end
         tick();
      end
      memwe = 1'b0; kb_valid = 1'b0; disp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit          known;
      logic [15:0] exp;
      int          budget;
      disp_ready = 1'b1;
      mar = 16'hFE04;
      budget = 0;
      while (!m_dsr() && budget < 100) begin
         tick();
         budget++;
      end
      vectors++; if (!m_dsr()) begin miscompares++; $display("FAIL idle_wait: got busy want idle within 100 cycles"); end
      disp_ready = 1'b0;
      kb_valid = 1'b1; kb_data = 8'h55;
      mar = 16'hFE06; mdr = 16'h0033; memwe = 1'b1; tick();
      memwe = 1'b0; kb_valid = 1'b0; mar = 16'hFE04; #1;
      vectors++; if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_valid: got %b want 1", disp_valid); end
      vectors++; if (kb_ready !== 1'b0) begin miscompares++; $display("FAIL pre_rst_kb_ready: got %b want 0", kb_ready); end
      #1;
      reset_n = 1'b0;
      #1;
      model_reset();
      vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", disp_valid); end
      vectors++; if (memOut !== 16'h8000) begin miscompares++; $display("FAIL rst_mid_dsr: got %h want 8000", memOut); end
      vectors++; if (kb_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_kb_ready: got %b want 1", kb_ready); end
      vectors++; if (disp_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_disp_data: got %h want 00", disp_data); end
      #1;
      reset_n = 1'b1;
      tick();
      mar = 16'h0010; #1;
      exp = exp_read(mar, known);
      vectors++; if (memOut !== exp) begin miscompares++; $display("FAIL ram_after_rst: got %h want %h", memOut, exp); end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_keyboard();
      test_kb_hold();
      test_display();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 core's memory port. It answers the core's `mar`/`mdr`/`memwe` accesses with a word-addressed RAM and the four standard LC-3 memory-mapped I/O registers. It also bridges the keyboard and display registers to valid/ready byte streams for the bench or an external UART. It sits beside the core in the top level, as the other end of its memory interface.

## Interface
- `ADDR_W`, 8: RAM address width in words; RAM depth is 2^ADDR_W.
- `DISP_DELAY`, 4: cycles after a display handshake before DSR ready returns; range 0..255.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mar` in 16: access address from the core.
- `mdr` in 16: write data from the core.
- `memwe` in 1: write strobe; one-cycle pulse from the core.
- `memOut` out 16: read data for the core's MDR load.
- `kb_data` in 8: incoming keyboard character.
- `kb_valid` in 1: `kb_data` is valid.
- `kb_ready` out 1: responder can accept a character.
- `disp_data` out 8: outgoing display character.
- `disp_valid` out 1: `disp_data` is valid.
- `disp_ready` in 1: sink accepts `disp_data`.

## Operation
- **Address decode:**
  - KBSR = xFE00, KBDR = xFE02, DSR = xFE04, DDR = xFE06.
  - RAM is hit when `mar[15:ADDR_W]==0`.
  - Any other address reads x0000, and writes to it are dropped.
- **Reads:** `memOut` is purely combinational from `mar`, with no wait states.
  - RAM: `mem[mar[ADDR_W-1:0]]`.
  - KBSR: {kb_rdy, kb_ie, 14'b0}.
  - KBDR: {8'h00, kb_char}.
  - DSR: {disp_rdy, 15'b0}.
  - DDR: {8'h00, disp_data}.
- **Writes:** take effect at the `clk` edge where `memwe`=1.
  - RAM: `mem[mar]` ← `mdr`.
  - KBSR: only bit 14 (`kb_ie`) is written; bit 15 is read-only. `kb_ie` is stored only; no interrupt is generated.
  - KBDR and DSR: writes are ignored.
  - DDR: see the display port below.
- **Keyboard port:**
  - `kb_ready` = !kb_rdy.
  - On `kb_valid && kb_ready`: kb_char ← `kb_data` and kb_rdy ← 1.
  - A KBDR read event clears kb_rdy at the next edge.
  - A read event is a cycle where `mar`==xFE02 and the registered previous `mar` differs. Holding `mar` at xFE02 therefore clears kb_rdy only once.
  - A new character cannot arrive in the same cycle as a clear, because `kb_ready` is 0 while kb_rdy=1.
- **Display port FSM** (`IDLE`, `SEND`, `HOLD`):
  - `IDLE`: disp_rdy=1, `disp_valid`=0. A DDR write latches `disp_data` ← `mdr[7:0]`, sets `disp_valid` ← 1, clears disp_rdy, and moves to `SEND`.
  - `SEND`: `disp_valid` and `disp_data` are held stable until `disp_ready`=1. At the handshake edge, `disp_valid` ← 0. If `DISP_DELAY`==0, go to `IDLE`; otherwise load the counter with `DISP_DELAY`-1 and go to `HOLD`.
  - `HOLD`: the counter decrements each cycle; at 0, go to `IDLE`.
  - A DDR write while disp_rdy=0 (in `SEND` or `HOLD`) is dropped. `disp_data` is unchanged.
- **RAM is not reset;** its contents are undefined until written.

## Timing
- **Reset values:**
  - kb_rdy=0, kb_ie=0, kb_char=0, so `kb_ready`=1.
  - FSM=`IDLE`, disp_rdy=1, `disp_data`=x00, `disp_valid`=0.
  - Registered previous `mar` = x0000.
- **Read latency:** 0 cycles. `memOut` follows `mar` combinationally, so the core's MDR load in the cycle after MAR load sees correct data.
- **Write visibility:** a write at edge E is visible on `memOut` in the cycle after E.
- **Keyboard:** after a handshake at edge E, KBSR reads x8000 (with `kb_ie`=0) from E onward. A KBDR read event in cycle C makes KBSR[15]=0 after edge C.
- **Display:** a DDR write at edge E gives `disp_valid`=1 after E. After the handshake edge H, DSR[15]=1 after edge H+DISP_DELAY.
- **Reset mid-operation:** an asynchronous assertion immediately drops any pending character and returns all registers to their reset values.

## Structure
- Shared package `lc3_mmio_pkg` holds:
  - localparams `KBSR_ADDR`, `KBDR_ADDR`, `DSR_ADDR`, `DDR_ADDR`;
  - typedef enum `disp_state_t` {`IDLE`, `SEND`, `HOLD`}.
- One sub-module: `lc3_disp_port`, containing the display FSM, hold counter, `disp_data` register and DSR ready bit.
- The RAM, address decode, keyboard logic and read mux stay in the top level.

## Test plan
- **RAM write/read:** write x1234 at x0010 with a 1-cycle `memwe`, then set `mar`=x0010 → `memOut`=x1234. Set `mar`=x0100 → `memOut`=x0000, and a write there has no effect.
- **Keyboard:** drive `kb_valid`=1 with `kb_data`=x41 → `kb_ready` drops. KBSR reads x8000, KBDR reads x0041. After the `mar` edge to xFE02, KBSR reads x0000 and `kb_ready`=1.
- **Keyboard hold:** hold `mar`=xFE02 while a second character x42 arrives → kb_rdy stays 1 (no new edge). Move `mar` away and back → kb_rdy clears.
- **Display with backpressure:** write x0158 to DDR with `disp_ready`=0 for 3 cycles → `disp_valid`=1 and `disp_data`=x58, stable for all 3 cycles, and DSR reads x0000. Handshake, then with `DISP_DELAY`=4, DSR reads x8000 exactly 4 edges later.
- **Dropped display write:** write DDR again during `HOLD` → dropped, `disp_data` remains x58.
- **Reset mid-operation:** pulse `reset_n` low during `SEND` → `disp_valid`=0, DSR=x8000, `kb_ready`=1 immediately, without waiting for a `clk` edge.
